// File: rtl/led_pattern_gen.sv
// LED pattern generator: drives the board LEDs from the control and period
// register words (static, blink, bouncing LED, PWM dimming), all paced by a
// programmable prescaler tick.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_DISABLED | LEDs off, counters held at their reset values
// S_LOAD     | one cycle: counters cleared, LEDs set to the pattern's start
// S_RUN      | prescaler running, pattern advances on each tick
module led_pattern_gen #(
    parameter int LED_W = 8,
    parameter int CNT_W = 32,
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ctrl_word,
    input  logic [CNT_W-1:0] period_word,
    output logic [LED_W-1:0] led_out,
    output logic             tick_out
);

    localparam int POS_W = (LED_W > 1) ? $clog2(LED_W) : 1;
    // Only enable, duty, pattern and mode take part in change detection.
    localparam logic [31:0] CTRL_MASK = 32'h80FF_FF03;

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_LOAD     = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic               tick_q, tick_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               blink_phase_q, blink_phase_d;
    logic [POS_W-1:0]   bounce_pos_q, bounce_pos_d;
    logic               bounce_down_q, bounce_down_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;

    logic               change;
    logic [1:0]         mode;
    logic [LED_W-1:0]   pattern;
    logic [PWM_W-1:0]   duty;
    logic [LED_W-1:0]   led_init;
    logic [POS_W-1:0]   pos_next;
    logic [PWM_W-1:0]   pwm_next;

    // Decode the shadowed control word and the pattern's starting output.
    always_comb begin
        mode     = ctrl_q[1:0];
        pattern  = LED_W'(ctrl_q[15:8]);
        duty     = PWM_W'(ctrl_q[23:16]);
        change   = ((ctrl_word & CTRL_MASK) != ctrl_q) || (period_word != period_q);
        led_init = pattern;
        if (mode == 2'd2) begin
            led_init = LED_W'(1);
        end else if (mode == 2'd3 && duty == '0) begin
            led_init = '0;
        end
    end

    // Next-state, prescaler and pattern stepping.
    always_comb begin
        state_d       = state_q;
        ctrl_d        = ctrl_word & CTRL_MASK;
        period_d      = period_word;
        presc_cnt_d   = presc_cnt_q;
        tick_d        = 1'b0;
        led_d         = led_q;
        blink_phase_d = blink_phase_q;
        bounce_pos_d  = bounce_pos_q;
        bounce_down_d = bounce_down_q;
        pwm_cnt_d     = pwm_cnt_q;
        pos_next      = bounce_pos_q;
        pwm_next      = pwm_cnt_q + PWM_W'(1);

        case (state_q)
            S_DISABLED: begin
                led_d         = '0;
                presc_cnt_d   = '0;
                blink_phase_d = 1'b1;
                bounce_pos_d  = '0;
                bounce_down_d = 1'b0;
                pwm_cnt_d     = '0;
                if (ctrl_word[31]) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                led_d         = led_init;
                presc_cnt_d   = '0;
                blink_phase_d = 1'b1;
                bounce_pos_d  = '0;
                bounce_down_d = 1'b0;
                pwm_cnt_d     = '0;
                // A change landing during the load cycle is already in the
                // shadow, so reload once more rather than miss it.
                if (!ctrl_word[31]) begin
                    state_d = S_DISABLED;
                end else if (change) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (!ctrl_word[31]) begin
                    state_d = S_DISABLED;
                end else if (change) begin
                    state_d = S_LOAD;
                end else if (presc_cnt_q == period_q) begin
                    presc_cnt_d = '0;
                    tick_d      = 1'b1;
                    case (mode)
                        2'd0: led_d = pattern;
                        2'd1: begin
                            blink_phase_d = ~blink_phase_q;
                            led_d         = blink_phase_q ? '0 : pattern;
                        end
                        2'd2: begin
                            if (bounce_down_q) begin
                                pos_next = bounce_pos_q - POS_W'(1);
                                if (pos_next == '0) begin
                                    bounce_down_d = 1'b0;
                                end
                            end else begin
                                pos_next = bounce_pos_q + POS_W'(1);
                                if (pos_next == POS_W'(LED_W - 1)) begin
                                    bounce_down_d = 1'b1;
                                end
                            end
                            bounce_pos_d = pos_next;
                            led_d        = LED_W'(1) << pos_next;
                        end
                        default: begin
                            pwm_cnt_d = pwm_next;
                            led_d     = (pwm_next < duty) ? pattern : '0;
                        end
                    endcase
                end else begin
                    presc_cnt_d = presc_cnt_q + CNT_W'(1);
                end
            end

            default: state_d = S_DISABLED;
        endcase
    end

    // State, shadow and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_DISABLED;
            ctrl_q        <= '0;
            period_q      <= '0;
            presc_cnt_q   <= '0;
            tick_q        <= 1'b0;
            led_q         <= '0;
            blink_phase_q <= 1'b1;
            bounce_pos_q  <= '0;
            bounce_down_q <= 1'b0;
            pwm_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            period_q      <= period_d;
            presc_cnt_q   <= presc_cnt_d;
            tick_q        <= tick_d;
            led_q         <= led_d;
            blink_phase_q <= blink_phase_d;
            bounce_pos_q  <= bounce_pos_d;
            bounce_down_q <= bounce_down_d;
            pwm_cnt_q     <= pwm_cnt_d;
        end
    end

    assign led_out  = led_q;
    assign tick_out = tick_q;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Fabric-side consumer of the AXI-lite register bank. It takes register word 0 (control) and register word 1 (period) and drives the 8 board LEDs.
- Supported patterns: static, blink, bouncing single LED, and PWM dimming.
- All timing derives from a programmable prescaler tick.
- Runs on the AXI clock, so no CDC is needed. Register words connect directly.

Parameters:
- LED_W, 8, number of LED outputs. Shift mode bounces over 0..LED_W-1.
- CNT_W, 32, prescaler counter width. Equal to the period word width.
- PWM_W, 8, PWM phase counter and duty width.

Ports:
- clk  in  1  system clock, same as the AXI register bank clock.
- rst  in  1  synchronous, active-high reset.
- ctrl_word  in  32  control register.
  - [1:0] mode: 0 = static, 1 = blink, 2 = bounce, 3 = pwm.
  - [15:8] pattern.
  - [23:16] duty.
  - [31] enable.
  - All other bits are ignored.
- period_word  in  CNT_W  prescaler reload. A tick occurs every period_word+1 clocks.
- led_out  out  LED_W  registered LED drive.
- tick_out  out  1  one-cycle pulse per prescaler tick, for debug and test.

Behaviour:
- Reset (rst=1 at a clk edge):
  - led_out=0, tick_out=0.
  - FSM=DISABLED.
  - Prescaler cnt=0.
  - blink phase=1, bounce pos=0, dir=up, pwm_cnt=0.
  - Shadow registers ctrl_q=0, period_q=0.
  - rst dominates every other condition, including mid-pattern.
- Shadowing: ctrl_q and period_q capture the inputs every cycle.
  - Only the masked bits [31], [23:16], [15:8], [1:0] are compared.
  - change = (masked ctrl_word != ctrl_q) or (period_word != period_q).
- FSM states: DISABLED, LOAD, RUN.
  - DISABLED: led_out=0, all counters held at reset values. Goes to LOAD when ctrl_word[31]=1.
  - LOAD (exactly 1 cycle):
    - Counters cleared to their reset values.
    - tick_out=0.
    - led_out is set to the pattern's initial output: static/blink = pattern; bounce = 0x01; pwm = (duty!=0) ? pattern : 0.
    - Goes to RUN.
  - RUN: normal operation.
    - If enable=0, go to DISABLED. led_out=0 on the next cycle.
    - Else if change, go to LOAD. Changes restart the pattern; there is no mid-pattern merge.
    - When enable=0 and change occur together, DISABLED wins.
- Prescaler (RUN only):
  - If cnt==period_q: cnt<=0 and tick_out<=1 for one cycle.
  - Else cnt<=cnt+1 and tick_out<=0.
  - period 0 gives a tick every cycle.
  - period 0xFFFFFFFF: cnt wraps via the equality compare only. There is no overflow path.
- Pattern update on each tick: the led_out update is registered in the same cycle tick_out is asserted, so both change together.
  - static: led_out = pattern, constant. The tick has no effect.
  - blink: phase toggles. led_out = phase ? pattern : 0.
  - bounce: led_out = 1<<pos.
    - Going up: pos+1, reversing direction when pos reaches LED_W-1.
    - Going down: pos-1, reversing at 0.
    - Sequence: 0,1,…,7,6,…,1,0,1,… Each endpoint is held for exactly one tick.
  - pwm: pwm_cnt increments and wraps 255→0. led_out = (pwm_cnt < duty) ? pattern : 0.
    - duty=0 is always off.
    - duty=255 is on for 255 of 256 ticks.
    - duty is compared as unsigned.
- Latency:
  - Input change → LOAD on the next edge → new initial output visible 2 clocks after the input change.
  - Enable falling → led_out=0 two clocks later (shadow, then FSM).
- pattern=0 in any mode gives led_out=0 but the counters still run. bounce ignores pattern.

Test Plan:
1. Reset: rst high 3 cycles with ctrl=0x8000_0100 → led_out=0, tick_out=0 during reset. Two cycles after release led_out=0x01 (static, pattern=0x01), and it never changes.
2. Blink: ctrl=0x8000_A501, period=3 → tick_out every 4 clocks. led_out alternates 0xA5, 0x00, 0xA5 …, toggling on the tick cycles.
3. Bounce: ctrl=0x8000_0002, period=0 → led_out per clock after LOAD: 01,02,04,…,80,40,…,01,02. Check both endpoints occur once each per 14-tick cycle.
4. PWM: ctrl=0x8040_FF03 (duty=0x40), period=0 → over 256 ticks exactly 64 have led_out=0xFF. duty=0 gives always 0; duty=255 gives exactly one 0x00 per 256 ticks.
5. Reconfigure mid-pattern: during bounce at pos=5, change period 0→1 → LOAD. led_out=0x01 two clocks later, and the counters restart (next tick 2 clocks after LOAD).
6. Disable/reset mid-operation: clear bit31 during PWM → led_out=0 within 2 clocks, FSM DISABLED. Re-enable → pattern restarts from its initial state. Asserting rst in RUN → all outputs 0 on the next edge.
